inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch unit assembling 32-bit little-endian words
//
// Purpose: reads one byte per acked request from a byte-wide memory port,
// assembles four bytes into an instruction word and presents it with its PC
// to the IF_ID stage until consumed. A jump redirect drops any partial or held
// instruction.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   jump_i          redirect request (highest priority)
//   jump_addr_i     redirect target, bits [1:0] forced to zero
//   stall_i         IF_ID cannot accept the held instruction
//   mem_req_o       byte read request (only in FETCH)
//   mem_addr_o      byte address of the request, zero when idle
//   mem_ack_i       request accepted, mem_data_i valid this cycle
//   mem_data_i      read byte
//   pc_o, inst_o    address and word of the presented instruction
//   inst_valid_o    pc_o/inst_o are valid for IF_ID

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  byte_cnt;
  logic [23:0] inst_buf;

  // Target is always word aligned; the low bits only exist on the port.
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Request is gated by rst so it drops the instant reset asserts and rises
  // in the very first cycle after release.
  assign mem_req_o  = (state == FETCH) && !rst;
  assign mem_addr_o = mem_req_o ? (pc + {30'b0, byte_cnt}) : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      byte_cnt     <= 2'd0;
      inst_buf     <= 24'h0;
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      inst_valid_o <= 1'b0;
    end else if (jump_i) begin
      // Any byte acked this cycle and any held instruction belong to the
      // old path and are dropped.
      state        <= FETCH;
      pc           <= {jump_addr_i[31:2], 2'b00};
      byte_cnt     <= 2'd0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack_i) begin
            if (byte_cnt == 2'd3) begin
              inst_o       <= {mem_data_i, inst_buf};
              pc_o         <= pc;
              inst_valid_o <= 1'b1;
              pc           <= pc + 32'd4;
              byte_cnt     <= 2'd0;
              state        <= VALID;
            end else begin
              inst_buf[{byte_cnt, 3'b000} +: 8] <= mem_data_i;
              byte_cnt                          <= byte_cnt + 2'd1;
            end
          end
        end
        VALID: begin
          if (!stall_i) begin
            inst_valid_o <= 1'b0;
            state        <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
